// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if : load/store unit and data-cache port signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int OPERAND_SIZE = 32,
  parameter int ID_SIZE      = 1
);
  logic                    load_req;
  logic [ADDRESS_SIZE-1:0] load_address;
  logic [ID_SIZE-1:0]      load_id;
  logic [ID_SIZE-1:0]      head;
  logic                    stall_in;
  logic                    store_req;
  logic [ADDRESS_SIZE-1:0] store_address;
  logic [OPERAND_SIZE-1:0] store_value;
  logic [OPERAND_SIZE-1:0] load_value;
  logic                    load_done;
  logic                    store_done;
  logic                    stall_load;
  logic                    stall_store;
  logic                    dismiss_output;
  logic                    cache_request;
  logic                    cache_write;
  logic [ADDRESS_SIZE-1:0] cache_address;
  logic [OPERAND_SIZE-1:0] cache_data;
  logic [OPERAND_SIZE-1:0] cache_result;
  logic                    cache_satisfied;

  modport slave (
    input  load_req, load_address, load_id, head, stall_in,
    input  store_req, store_address, store_value,
    input  cache_result, cache_satisfied,
    output load_value, load_done, store_done, stall_load, stall_store,
    output dismiss_output, cache_request, cache_write, cache_address, cache_data
  );

  modport master (
    output load_req, load_address, load_id, head, stall_in,
    output store_req, store_address, store_value,
    output cache_result, cache_satisfied,
    input  load_value, load_done, store_done, stall_load, stall_store,
    input  dismiss_output, cache_request, cache_write, cache_address, cache_data
  );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_port_arbiter : registered, starvation-bounded load/store dcache arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int OPERAND_SIZE = 32,
  parameter int ID_SIZE      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_LOAD  = 2'd1;
  localparam logic [1:0] c_S_STORE = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_next_state;
  logic [c_CW-1:0]         r_starve_cnt;
  logic [ADDRESS_SIZE-1:0] r_cache_address;
  logic [OPERAND_SIZE-1:0] r_cache_data;
  logic [OPERAND_SIZE-1:0] r_load_value;
  logic                    r_load_done;
  logic                    r_store_done;
  logic [ID_SIZE-1:0]      w_load_id;
  logic                    w_load_elig;
  logic                    w_store_elig;
  logic                    w_grant_load;
  logic                    w_grant_store;
  logic                    w_complete;

  assign w_load_id    = bus.load_id;
  assign w_load_elig  = bus.load_req && !bus.stall_in && (w_load_id == bus.head);
  assign w_store_elig = bus.store_req;

  // Stores win by default; a load waiting through STARVE_LIMIT store grants wins next.
  assign w_grant_load  = (r_state == c_S_IDLE) && !reset && w_load_elig &&
                         (!w_store_elig || (r_starve_cnt == c_LIMIT));
  assign w_grant_store = (r_state == c_S_IDLE) && !reset && w_store_elig && !w_grant_load;
  assign w_complete    = (r_state != c_S_IDLE) && bus.cache_satisfied;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_grant_load) begin
          w_next_state = c_S_LOAD;
        end else if (w_grant_store) begin
          w_next_state = c_S_STORE;
        end
      end
      c_S_LOAD, c_S_STORE: begin
        if (bus.cache_satisfied) begin
          w_next_state = c_S_IDLE;
        end
      end
      default: w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    bus.cache_request  = (r_state != c_S_IDLE);
    bus.cache_write    = (r_state == c_S_STORE);
    bus.dismiss_output = (r_state == c_S_STORE);
    bus.stall_load     = bus.load_req && !w_grant_load;
    bus.stall_store    = bus.store_req && !w_grant_store;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt    <= '0;
      r_cache_address <= '0;
      r_cache_data    <= '0;
      r_load_value    <= '0;
      r_load_done     <= 1'b0;
      r_store_done    <= 1'b0;
    end else begin
      r_load_done  <= w_complete && (r_state == c_S_LOAD);
      r_store_done <= w_complete && (r_state == c_S_STORE);
      if (w_complete && (r_state == c_S_LOAD)) begin
        r_load_value <= bus.cache_result;
      end
      if (w_grant_load) begin
        r_cache_address <= bus.load_address;
        r_starve_cnt    <= '0;
      end else if (w_grant_store) begin
        r_cache_address <= bus.store_address;
        r_cache_data    <= bus.store_value;
        if (!w_load_elig) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + c_CW'(1);
        end
      end
    end
  end

  assign bus.cache_address = r_cache_address;
  assign bus.cache_data    = r_cache_data;
  assign bus.load_value    = r_load_value;
  assign bus.load_done     = r_load_done;
  assign bus.store_done    = r_store_done;
endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single data-cache port between the load unit and the store unit.
- Grants one request at a time and holds that request stable at the cache until the cache signals satisfied.
- Returns load data and completion pulses to the winning requester.
- Sits between the load/store stage and the direct-mapped data cache. Replaces the combinational store-always-wins port select with a registered, starvation-bounded arbiter.

Parameters:
ADDRESS_SIZE, 32, width of load/store/cache addresses
OPERAND_SIZE, 32, width of store data and load result
ID_SIZE, 1, width of load ordering id and head pointer
STARVE_LIMIT, 4, consecutive store grants allowed while a load is eligible and waiting

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
load_req  in  1  load request valid
load_address  in  ADDRESS_SIZE  load byte address
load_id  in  ID_SIZE  ordering id of presented load
head  in  ID_SIZE  id of oldest in-flight instruction
stall_in  in  1  downstream stall; blocks new load grants
store_req  in  1  store request valid
store_address  in  ADDRESS_SIZE  store byte address
store_value  in  OPERAND_SIZE  store data
load_value  out  OPERAND_SIZE  registered load result
load_done  out  1  one-cycle pulse, load complete
store_done  out  1  one-cycle pulse, store complete
stall_load  out  1  load must hold its request
stall_store  out  1  store must hold its request
dismiss_output  out  1  high while a store owns the port
cache_request  out  1  request to cache
cache_write  out  1  1 = write, 0 = read
cache_address  out  ADDRESS_SIZE  latched address
cache_data  out  OPERAND_SIZE  latched store data
cache_result  in  OPERAND_SIZE  cache read data
cache_satisfied  in  1  cache completed current request

Behaviour:
- Eligibility:
  - load_elig = load_req && !stall_in && (load_id == head).
  - store_elig = store_req.
- States: IDLE, LOAD_BUSY, STORE_BUSY. All state is registered and changes only on the rising edge of clk.
- IDLE:
  - If both are eligible: grant the store unless starve_cnt == STARVE_LIMIT, in which case grant the load.
  - If only one is eligible: grant it.
  - On grant, latch address and data into cache_address/cache_data, then go to LOAD_BUSY or STORE_BUSY.
- BUSY:
  - cache_request = 1. cache_write = 1 in STORE_BUSY, 0 in LOAD_BUSY.
  - Latched cache outputs stay constant until cache_satisfied.
- Completion, on the first edge where cache_satisfied = 1 in BUSY:
  - Return to IDLE.
  - Pulse load_done (and register load_value <= cache_result) or pulse store_done for exactly one cycle.
  - No new grant on that same edge. The minimum turnaround is grant, then at least 1 busy cycle, then 1 idle cycle.
- Latency: with cache_satisfied asserted the cycle after grant, done pulses 2 cycles after the request is first sampled in IDLE.
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments on a store grant while load_elig = 1.
  - Clears on any load grant, or on a store grant with load_elig = 0.
  - Saturates at STARVE_LIMIT.
- stall_load = load_req && !(state == IDLE && load wins this cycle). stall_store = store_req && !(state == IDLE && store wins this cycle). A requester must hold its inputs stable while its stall is high.
- dismiss_output = (state == STORE_BUSY).
- cache_satisfied in IDLE is ignored. Changes of load_req/store_req/stall_in in BUSY do not affect the in-flight request.
- Reset (synchronous, any state, including mid-transaction):
  - state = IDLE, starve_cnt = 0.
  - cache_request = 0, cache_write = 0, cache_address = 0, cache_data = 0.
  - load_value = 0, load_done = 0, store_done = 0, dismiss_output = 0.
  - An in-flight transaction is abandoned with no done pulse. The cache is expected to be reset by the same signal.
- stall_load/stall_store are combinational from the inputs and state. They equal load_req/store_req while reset is high.

Test Plan:
- Lone load: load_req=1, load_address=0x10, load_id=head=0, cache_satisfied one cycle after grant, cache_result=0xDEADBEEF -> cache_write=0, load_done pulses once, load_value=0xDEADBEEF, stall_load falls in the grant cycle.
- Lone store: store_address=0x20, store_value=0x12345678, satisfied after 3 busy cycles -> cache_write=1, cache_address/cache_data held constant for all 3 cycles, dismiss_output=1 throughout, then a single store_done.
- Simultaneous eligible load and store, STARVE_LIMIT=4, store_req held high continuously -> stores granted 4 times, then the 5th grant goes to the load; starve_cnt returns to 0.
- Load gating: load_req=1, load_id=1, head=0 (or stall_in=1) with no store -> no grant, stall_load stays 1; set head=1 -> grant next edge.
- Reset mid-transaction: reset asserted in STORE_BUSY before satisfied -> next cycle all outputs 0, no store_done; after release, a pending load is granted normally.
- Back-to-back: load completes, store pending -> store grant occurs exactly 1 cycle after load_done, never on the same edge.
